// File: rtl/enigma_symb_rx_if.sv
// rtl/enigma_symb_rx_if.sv - symbol stream, consumer handshake and status bundle for enigma_symb_rx
//
// Purpose: groups every non-clock/reset signal of enigma_symb_rx.
// Signals:
//   in_symb_i    encoded symbol from the encoder, 0 = idle
//   clr_i        synchronous clear of counters and sticky flags
//   out_ready_i  consumer accepts the head entry
//   out_symb_o   FIFO head symbol (0 when empty)
//   out_valid_o  head entry valid
//   level_o      FIFO occupancy
//   ovf_o        sticky overflow (letter dropped on full FIFO)
//   err_o        sticky out-of-range code seen
//   symb_cnt_o   saturating count of pushed symbols
//   err_cnt_o    saturating count of out-of-range codes
// Modports: master = driver/consumer side, slave = enigma_symb_rx.

interface enigma_symb_rx_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    logic [5:0]               in_symb_i;
    logic                     clr_i;
    logic                     out_ready_i;
    logic [5:0]               out_symb_o;
    logic                     out_valid_o;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     ovf_o;
    logic                     err_o;
    logic [CNT_W-1:0]         symb_cnt_o;
    logic [7:0]               err_cnt_o;

    modport master (
        output in_symb_i, clr_i, out_ready_i,
        input  out_symb_o, out_valid_o, level_o, ovf_o, err_o, symb_cnt_o, err_cnt_o
    );

    modport slave (
        input  in_symb_i, clr_i, out_ready_i,
        output out_symb_o, out_valid_o, level_o, ovf_o, err_o, symb_cnt_o, err_cnt_o
    );
endinterface

// File: rtl/enigma_symb_rx.sv
// rtl/enigma_symb_rx.sv - receive-side Enigma symbol collector with FIFO and statistics
//
// Purpose: registers the 6-bit symbol stream, classifies it (0 idle, 1..26
// letter, 27..63 error), pushes letters into a DEPTH-entry FIFO drained by a
// valid/ready consumer, and keeps saturating symbol/error counters plus sticky
// overflow/error flags.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   bus    enigma_symb_rx_if.slave (stream input, consumer handshake, status)
// Parameters: DEPTH (power of two, 2..64), CNT_W (symbol counter width).
// Optional build macro: ENIGMA_RX_HOLD_DEDUP_EN - capture a held nonzero code
// only once; a new capture needs the previously sampled code to differ.

module enigma_symb_rx #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    enigma_symb_rx_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] SYMB_MAX = '1;
    localparam logic [7:0]       ERR_MAX  = 8'hFF;

    logic [5:0]       in_q,       in_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0] level_q,    level_d;
    logic [CNT_W-1:0] symb_cnt_q, symb_cnt_d;
    logic [7:0]       err_cnt_q,  err_cnt_d;
    logic             ovf_q,      ovf_d;
    logic             err_q,      err_d;
`ifdef ENIGMA_RX_HOLD_DEDUP_EN
    logic [5:0]       in_prev_q,  in_prev_d;
`endif

    logic [5:0] mem_q [DEPTH];

    logic is_new;
    logic cand;
    logic bad;
    logic out_valid;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        in_d = bus.in_symb_i;
`ifdef ENIGMA_RX_HOLD_DEDUP_EN
        // Edge rule: a sampled code counts only if it differs from the one
        // sampled the cycle before (an idle 0 in between also re-arms it).
        in_prev_d = in_q;
        is_new    = (in_q != in_prev_q);
`else
        is_new    = 1'b1;
`endif
        cand      = (in_q >= 6'd1) && (in_q <= 6'd26) && is_new;
        bad       = (in_q >= 6'd27) && is_new;
        out_valid = (level_q != '0);
        full      = (level_q == FULL_LVL);
        pop       = out_valid && bus.out_ready_i;
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        push      = cand && (!full || pop);
        drop      = cand && !push;

        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        symb_cnt_d = symb_cnt_q;
        err_cnt_d  = err_cnt_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        if (bus.clr_i) begin
            // Clear takes priority over any same-cycle event.
            symb_cnt_d = '0;
            err_cnt_d  = '0;
            ovf_d      = 1'b0;
            err_d      = 1'b0;
        end else begin
            if (push && (symb_cnt_q != SYMB_MAX)) symb_cnt_d = symb_cnt_q + CNT_W'(1);
            if (drop) ovf_d = 1'b1;
            if (bad) begin
                err_d = 1'b1;
                if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            symb_cnt_q <= '0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef ENIGMA_RX_HOLD_DEDUP_EN
            in_prev_q  <= '0;
`endif
        end else begin
            in_q       <= in_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            symb_cnt_q <= symb_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
`ifdef ENIGMA_RX_HOLD_DEDUP_EN
            in_prev_q  <= in_prev_d;
`endif
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever level is 0.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_q;
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_symb_o  = out_valid ? mem_q[rd_ptr_q] : 6'd0;
    assign bus.level_o     = level_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.err_o       = err_q;
    assign bus.symb_cnt_o  = symb_cnt_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_enigma_symb_rx.sv
// tb/tb_enigma_symb_rx.sv - self-checking bench for enigma_symb_rx

module tb_enigma_symb_rx;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
`ifdef ENIGMA_RX_HOLD_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enigma_symb_rx_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    enigma_symb_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO as a queue, counters as plain integers.
    int q[$];
    int m_cur, m_samp, m_prev;
    bit m_rdy, m_clr;
    int m_symb, m_errc;
    bit m_ovf, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_samp = 0; m_prev = 0;
        m_symb = 0; m_errc = 0;
        m_ovf = 0;  m_err = 0;
    endtask

    task automatic drive(input int sym, input bit rdy, input bit clr);
        m_cur = sym; m_rdy = rdy; m_clr = clr;
        bus.in_symb_i   = sym[5:0];
        bus.out_ready_i = rdy;
        bus.clr_i       = clr;
    endtask

    // Apply one clock edge to the model, then to the DUT; return at edge+1.
    task automatic tick();
        int  s;
        bit  fresh, letter, bad, pop, push;
        if (!rst_n) begin
            model_reset();
        end else begin
            s      = m_samp;
            fresh  = DEDUP ? (s != m_prev) : 1'b1;
            letter = (s >= 1) && (s <= 26) && fresh;
            bad    = (s >= 27) && fresh;
            pop    = (q.size() > 0) && m_rdy;
            push   = letter && ((q.size() < DEPTH) || pop);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(s);
            if (m_clr) begin
                m_symb = 0; m_errc = 0; m_ovf = 0; m_err = 0;
            end else begin
                if (push && m_symb < 65535) m_symb++;
                if (letter && !push) m_ovf = 1;
                if (bad) begin
                    m_err = 1;
                    if (m_errc < 255) m_errc++;
                end
            end
            m_prev = s;
            m_samp = m_cur;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(bus.level_o), 32'(q.size()));
        chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'(q.size() != 0));
        chk({tag, ".head"},  32'(bus.out_symb_o), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".ovf"},   32'(bus.ovf_o), 32'(m_ovf));
        chk({tag, ".err"},   32'(bus.err_o), 32'(m_err));
        chk({tag, ".scnt"},  32'(bus.symb_cnt_o), 32'(m_symb));
        chk({tag, ".ecnt"},  32'(bus.err_cnt_o), 32'(m_errc));
    endtask

    task automatic step(input int sym, input bit rdy, input bit clr, input string tag);
        drive(sym, rdy, clr);
        tick();
        check_all(tag);
    endtask

    initial begin
        int seq5[5];
        int errseq[5];
        int sym, prev_sym;
        bit rdy;
        seq5   = '{8, 5, 12, 12, 15};
        errseq = '{4, 27, 9, 63, 10};
        model_reset();
        drive(0, 0, 0);

        // Reset state
        tick();
        tick();
        check_all("reset");
        chk("reset.symb_out", 32'(bus.out_symb_o), 32'd0);
        rst_n = 1'b1;

        // One symbol per 5-cycle slot, consumer always ready
        for (int i = 0; i < 5; i++) begin
            step(seq5[i], 1, 0, "slot");
            step(0, 1, 0, "slot");
            chk("slot.visible2", 32'(bus.out_symb_o), 32'(seq5[i]));
            for (int k = 0; k < 3; k++) step(0, 1, 0, "slot");
        end
        chk("slot.symb_cnt5", 32'(bus.symb_cnt_o), 32'd5);

        // Overflow: 17 pushes into a stalled 16-deep FIFO
        step(0, 0, 1, "clr");
        for (int i = 1; i <= 17; i++) step(i, 0, 0, "fill");
        step(0, 0, 0, "fill");
        step(0, 0, 0, "fill");
        chk("ovf.level16", 32'(bus.level_o), 32'd16);
        chk("ovf.flag", 32'(bus.ovf_o), 32'd1);
        chk("ovf.symb_cnt16", 32'(bus.symb_cnt_o), 32'd16);
        for (int i = 0; i < 18; i++) step(0, 1, 0, "drain");

        // Out-of-range codes, then clear with a non-empty FIFO
        step(0, 0, 1, "clr");
        for (int i = 0; i < 5; i++) step(errseq[i], 0, 0, "err");
        step(0, 0, 0, "err");
        step(0, 0, 0, "err");
        chk("err.flag", 32'(bus.err_o), 32'd1);
        chk("err.cnt2", 32'(bus.err_cnt_o), 32'd2);
        chk("err.level3", 32'(bus.level_o), 32'd3);
        step(0, 0, 1, "clr");
        chk("clr.err", 32'(bus.err_o), 32'd0);
        chk("clr.ecnt", 32'(bus.err_cnt_o), 32'd0);
        chk("clr.scnt", 32'(bus.symb_cnt_o), 32'd0);
        chk("clr.level_kept", 32'(bus.level_o), 32'd3);
        for (int i = 0; i < 4; i++) step(0, 1, 0, "drain");

        // Full FIFO with continuous push and pop across pointer wrap
        step(0, 0, 1, "clr");
        for (int i = 0; i < 40; i++) begin
            step((i % 26) + 1, (i >= 17), 0, "wrap");
            if (i >= 16) chk("wrap.level16", 32'(bus.level_o), 32'd16);
        end
        step(0, 1, 0, "wrap");
        chk("wrap.no_ovf", 32'(bus.ovf_o), 32'd0);
        for (int i = 0; i < 18; i++) step(0, 1, 0, "drain");

        // Held code
        step(0, 0, 1, "clr");
        for (int i = 0; i < 3; i++) step(3, 0, 0, "hold");
        for (int i = 0; i < 3; i++) step(0, 0, 0, "hold");
        chk("hold.pushes", 32'(bus.symb_cnt_o), DEDUP ? 32'd1 : 32'd3);
        for (int i = 0; i < 4; i++) step(0, 1, 0, "drain");

        // Asynchronous reset mid-stream with 5 entries
        for (int i = 0; i < 5; i++) step(20 + i, 0, 0, "pre_rst");
        step(0, 0, 0, "pre_rst");
        step(0, 0, 0, "pre_rst");
        chk("pre_rst.level5", 32'(bus.level_o), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rst.valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst.level", 32'(bus.level_o), 32'd0);
        model_reset();
        tick();
        check_all("in_rst");
        rst_n = 1'b1;
        step(7, 1, 0, "post_rst");
        step(0, 1, 0, "post_rst");
        chk("post_rst.valid", 32'(bus.out_valid_o), 32'd1);
        chk("post_rst.head7", 32'(bus.out_symb_o), 32'd7);
        step(0, 1, 0, "post_rst");

        // Randomized traffic
        prev_sym = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 11));
            if (r < 4)       sym = 0;
            else if (r < 9)  sym = int'($urandom_range(1, 26));
            else if (r < 10) sym = int'($urandom_range(27, 63));
            else             sym = prev_sym;
            prev_sym = sym;
            rdy = ($urandom_range(0, 9) < 6);
            step(sym, rdy, ($urandom_range(0, 49) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
